// File: rtl/uart_cmd_host_tx_if.sv
// Command handshake bundle between a command source and uart_cmd_host_tx.
// The master drives the request and its fields; the slave returns cmd_ready.
interface uart_cmd_host_tx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [7:0] cmd_opA;
    logic [7:0] cmd_opB;
    logic [3:0] cmd_fun;

    modport master (
        output cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_opA, cmd_opB, cmd_fun,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_opA, cmd_opB, cmd_fun,
        output cmd_ready
    );
endinterface

// File: rtl/uart_cmd_host_tx.sv
// Host-side UART command initiator: turns one handshake into a byte-frame sequence on Tx_out.
// Optional abort support is built when UART_CMD_HOST_ABORT_EN is defined.
module uart_cmd_host_tx #(
    parameter int GAP_BITS = 1,
    parameter int PRE_W    = 6
) (
    input  logic              CLK,
    input  logic              Reset,
    uart_cmd_host_tx_if.slave cmd_if,
    input  logic              Parity_EN,
    input  logic              Parity_type,
    input  logic [PRE_W-1:0]  Prescale,
`ifdef UART_CMD_HOST_ABORT_EN
    input  logic              cmd_abort,
    output logic              cmd_aborted,
`endif
    output logic              Tx_out,
    output logic              Busy,
    output logic              cmd_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_e;

    localparam logic [15:0]      GAP_RELOAD = (GAP_BITS > 0) ? 16'(GAP_BITS - 1) : 16'd0;
    localparam logic [PRE_W-1:0] PRE_ZERO   = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE    = {{(PRE_W-1){1'b0}}, 1'b1};

    function automatic logic [7:0] frame_byte(
        input logic [1:0] typ,
        input logic [1:0] idx,
        input logic [7:0] addr,
        input logic [7:0] data,
        input logic [7:0] opa,
        input logic [7:0] opb,
        input logic [3:0] fun
    );
        logic [7:0] b;
        b = 8'h00;
        case (typ)
            2'd0: begin
                case (idx)
                    2'd0:    b = 8'hAA;
                    2'd1:    b = addr;
                    2'd2:    b = data;
                    default: b = 8'h00;
                endcase
            end
            2'd1: begin
                case (idx)
                    2'd0:    b = 8'hBB;
                    2'd1:    b = addr;
                    default: b = 8'h00;
                endcase
            end
            2'd2: begin
                case (idx)
                    2'd0:    b = 8'hCC;
                    2'd1:    b = opa;
                    2'd2:    b = opb;
                    2'd3:    b = {4'b0000, fun};
                    default: b = 8'h00;
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    b = 8'hDD;
                    2'd1:    b = {4'b0000, fun};
                    default: b = 8'h00;
                endcase
            end
        endcase
        return b;
    endfunction

    function automatic logic [1:0] last_index(input logic [1:0] typ);
        logic [1:0] n;
        case (typ)
            2'd0:    n = 2'd2;
            2'd1:    n = 2'd1;
            2'd2:    n = 2'd3;
            default: n = 2'd1;
        endcase
        return n;
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

    state_e           state_q, state_d;
    logic [PRE_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] reload_q, reload_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       typ_q, typ_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       opa_q, opa_d;
    logic [7:0]       opb_q, opb_d;
    logic [3:0]       fun_q, fun_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic [15:0]      gap_q, gap_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_CMD_HOST_ABORT_EN
    logic             abort_q, abort_d;
    logic             aborted_q, aborted_d;
`endif

    logic [7:0]       cur_byte_s;
    logic             bit_end_s;
    logic [PRE_W-1:0] eff_reload_s;
    logic             abort_now_s;

    assign cur_byte_s   = frame_byte(typ_q, byte_q, addr_q, data_q, opa_q, opb_q, fun_q);
    assign bit_end_s    = (cnt_q == PRE_ZERO);
    assign eff_reload_s = (Prescale == PRE_ZERO) ? PRE_ZERO : (Prescale - PRE_ONE);
`ifdef UART_CMD_HOST_ABORT_EN
    assign abort_now_s  = abort_q | cmd_abort;
    assign cmd_aborted  = aborted_q;
`else
    assign abort_now_s  = 1'b0;
`endif

    assign cmd_if.cmd_ready = (state_q == S_IDLE);
    assign Tx_out           = tx_q;
    assign Busy             = busy_q;
    assign cmd_done         = done_q;

    // Next-state, bit timing and line value for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        last_d    = last_q;
        typ_d     = typ_q;
        addr_d    = addr_q;
        data_d    = data_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        fun_d     = fun_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        gap_d     = gap_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_CMD_HOST_ABORT_EN
        aborted_d = 1'b0;
        if (state_q == S_IDLE) begin
            abort_d = 1'b0;
        end else if (cmd_abort) begin
            abort_d = 1'b1;
        end else begin
            abort_d = abort_q;
        end
`endif

        if (state_q == S_IDLE) begin
            cnt_d = cnt_q;
        end else if (bit_end_s) begin
            cnt_d = reload_q;
        end else begin
            cnt_d = cnt_q - PRE_ONE;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (cmd_if.cmd_valid) begin
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = eff_reload_s;
                    reload_d  = eff_reload_s;
                    bit_d     = 3'd0;
                    byte_d    = 2'd0;
                    last_d    = last_index(cmd_if.cmd_type);
                    typ_d     = cmd_if.cmd_type;
                    addr_d    = cmd_if.cmd_addr;
                    data_d    = cmd_if.cmd_data;
                    opa_d     = cmd_if.cmd_opA;
                    opb_d     = cmd_if.cmd_opB;
                    fun_d     = cmd_if.cmd_fun;
                    par_en_d  = Parity_EN;
                    par_odd_d = Parity_type;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte_s[0];
                end else begin
                    tx_d = 1'b0;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    if (bit_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = parity_bit(cur_byte_s, par_odd_q);
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte_s[bit_d];
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    tx_d = tx_q;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    if ((byte_q == last_q) || abort_now_s) begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
`ifdef UART_CMD_HOST_ABORT_EN
                        if (abort_now_s) begin
                            aborted_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
`else
                        done_d  = 1'b1;
`endif
                    end else if (GAP_BITS > 0) begin
                        state_d = S_GAP;
                        tx_d    = 1'b1;
                        gap_d   = GAP_RELOAD;
                        byte_d  = byte_q + 2'd1;
                    end else begin
                        state_d = S_START;
                        tx_d    = 1'b0;
                        byte_d  = byte_q + 2'd1;
                    end
                end else begin
                    tx_d = 1'b1;
                end
            end
            S_GAP: begin
                // An abort seen between bytes drops the rest of the command at the next bit boundary.
                if (bit_end_s) begin
                    if (abort_now_s) begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
`ifdef UART_CMD_HOST_ABORT_EN
                        aborted_d = 1'b1;
`else
                        done_d    = 1'b1;
`endif
                    end else if (gap_q == 16'd0) begin
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        gap_d = gap_q - 16'd1;
                        tx_d  = 1'b1;
                    end
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces an idle (mark) line.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= PRE_ZERO;
            reload_q  <= PRE_ZERO;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            last_q    <= 2'd0;
            typ_q     <= 2'd0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            opa_q     <= 8'h00;
            opb_q     <= 8'h00;
            fun_q     <= 4'h0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            gap_q     <= 16'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_CMD_HOST_ABORT_EN
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            typ_q     <= typ_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            fun_q     <= fun_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            gap_q     <= gap_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_CMD_HOST_ABORT_EN
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
`endif
        end
    end

endmodule
